// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi
//   Multi-approach traffic signal controller. One approach at a time holds
//   right-of-way and cycles GREEN -> YELLOW -> ALLRED before the next
//   approach, picked round-robin from latched demand, gets GREEN. A flash
//   mode parks the junction in an all-approach yellow/dark flashing pattern.
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   reset      : asynchronous, active-high reset
//   tick       : timebase enable, phase timers only advance when high
//   req        : per-approach demand, latched into a sticky pending register
//   flash_mode : level, requests flashing mode
//   light      : packed per-approach code, [2i+1:2i] = approach i
//                (00 green, 01 yellow, 10 red, 11 dark)
//   active_dir : approach currently holding right-of-way
//   phase_done : one-cycle pulse the cycle after every phase change
module traffic_ctrl_multi #(
   parameter int N_DIR        = 4,
   parameter int GREEN_TICKS  = 8,
   parameter int YELLOW_TICKS = 3,
   parameter int ALLRED_TICKS = 2,
   parameter int CNT_W        = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic [N_DIR-1:0]   req,
   input  logic               flash_mode,
   output logic [2*N_DIR-1:0] light,
   output logic [2:0]         active_dir,
   output logic               phase_done
);

   typedef enum logic [1:0] {
      ST_GREEN  = 2'd0,
      ST_YELLOW = 2'd1,
      ST_ALLRED = 2'd2,
      ST_FLASH  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0]   GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0]   YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0]   ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);
   localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [N_DIR-1:0]   ONE_DIR     = {{(N_DIR-1){1'b0}}, 1'b1};
   localparam logic [2*N_DIR-1:0] ALL_RED     = {N_DIR{2'b10}};
   localparam logic [2*N_DIR-1:0] ALL_YELLOW  = {N_DIR{2'b01}};
   localparam logic [2*N_DIR-1:0] ALL_DARK    = {N_DIR{2'b11}};
   localparam logic [2*N_DIR-1:0] SLOT0       = {{(2*N_DIR-2){1'b0}}, 2'b11};

   state_t             state_r, state_s;
   logic [CNT_W-1:0]   timer_r, timer_s;
   logic [N_DIR-1:0]   pend_r, pend_s;
   logic [N_DIR-1:0]   dir_oh_s, nxt_oh_s, req_eff_s;
   logic [2:0]         dir_s;
   logic               flash_ph_r, flash_ph_s;
   logic               others_pend_s;

   // Round-robin pick: first pending approach after cur (wrapping, cur itself
   // last); with nothing pending, simply the next approach.
   function automatic logic [2:0] rr_next(input logic [2:0] cur, input logic [N_DIR-1:0] p);
      logic [2:0] pick;
      logic       found;
      int         idx;
      pick  = (int'(cur) == N_DIR - 1) ? 3'd0 : cur + 3'd1;
      found = 1'b0;
      for (int k = 1; k <= N_DIR; k++) begin
         idx = (int'(cur) + k) % N_DIR;
         if (!found && (|(p & (ONE_DIR << idx)))) begin
            pick  = 3'(idx);
            found = 1'b1;
         end else begin
            pick  = pick;
         end
      end
      return pick;
   endfunction

   // Light pattern for a given phase, active approach and flash phase.
   function automatic logic [2*N_DIR-1:0] light_of(input state_t st, input logic [2:0] dir,
                                                   input logic ph);
      logic [2*N_DIR-1:0] mask;
      logic [2*N_DIR-1:0] res;
      mask = SLOT0 << {dir, 1'b0};
      case (st)
         ST_GREEN:  res = ALL_RED & ~mask;
         ST_YELLOW: res = (ALL_RED & ~mask) | (ALL_YELLOW & mask);
         ST_ALLRED: res = ALL_RED;
         ST_FLASH:  res = ph ? ALL_DARK : ALL_YELLOW;
         default:   res = ALL_RED;
      endcase
      return res;
   endfunction

   // Next-state, timer, selection and pending-demand logic.
   always_comb begin
      state_s       = state_r;
      timer_s       = timer_r;
      dir_s         = active_dir;
      flash_ph_s    = flash_ph_r;
      dir_oh_s      = ONE_DIR << active_dir;
      others_pend_s = |(pend_r & ~dir_oh_s);
      case (state_r)
         ST_GREEN: begin
            if (flash_mode) begin
               state_s = ST_YELLOW;
               timer_s = YELLOW_LOAD;
            end else if (!tick) begin
               timer_s = timer_r;
            end else if (timer_r != CNT_ZERO) begin
               timer_s = timer_r - CNT_ONE;
            end else if (others_pend_s) begin
               state_s = ST_YELLOW;
               timer_s = YELLOW_LOAD;
            end else begin
               // expired with no competing demand: hold green at zero
               timer_s = timer_r;
            end
         end
         ST_YELLOW: begin
            if (!tick) begin
               timer_s = timer_r;
            end else if (timer_r != CNT_ZERO) begin
               timer_s = timer_r - CNT_ONE;
            end else begin
               state_s = ST_ALLRED;
               timer_s = ALLRED_LOAD;
            end
         end
         ST_ALLRED: begin
            if (!tick) begin
               timer_s = timer_r;
            end else if (timer_r != CNT_ZERO) begin
               timer_s = timer_r - CNT_ONE;
            end else if (flash_mode) begin
               state_s    = ST_FLASH;
               timer_s    = CNT_ZERO;
               flash_ph_s = 1'b0;
            end else begin
               state_s = ST_GREEN;
               timer_s = GREEN_LOAD;
               dir_s   = rr_next(active_dir, pend_r);
            end
         end
         ST_FLASH: begin
            if (!flash_mode) begin
               state_s = ST_ALLRED;
               timer_s = ALLRED_LOAD;
            end else if (tick) begin
               flash_ph_s = ~flash_ph_r;
            end else begin
               flash_ph_s = flash_ph_r;
            end
         end
         default: begin
            state_s    = ST_GREEN;
            timer_s    = GREEN_LOAD;
            dir_s      = 3'd0;
            flash_ph_s = 1'b0;
         end
      endcase
      // the approach being served cannot re-arm its own demand while green
      if (state_r == ST_GREEN) begin
         req_eff_s = req & ~dir_oh_s;
      end else begin
         req_eff_s = req;
      end
      // entering green clears that approach's demand; clear beats a new set
      nxt_oh_s = ONE_DIR << dir_s;
      if ((state_s == ST_GREEN) && (state_r != ST_GREEN)) begin
         pend_s = (pend_r | req_eff_s) & ~nxt_oh_s;
      end else begin
         pend_s = pend_r | req_eff_s;
      end
   end

   // State registers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_GREEN;
         timer_r    <= GREEN_LOAD;
         pend_r     <= {N_DIR{1'b0}};
         flash_ph_r <= 1'b0;
         active_dir <= 3'd0;
         phase_done <= 1'b0;
         light      <= light_of(ST_GREEN, 3'd0, 1'b0);
      end else begin
         state_r    <= state_s;
         timer_r    <= timer_s;
         pend_r     <= pend_s;
         flash_ph_r <= flash_ph_s;
         active_dir <= dir_s;
         phase_done <= (state_s != state_r);
         light      <= light_of(state_s, dir_s, flash_ph_s);
      end
   end

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
module tb_traffic_ctrl_multi;

   localparam int G = 4;
   localparam int Y = 2;
   localparam int A = 1;
   localparam int PG = 0;
   localparam int PY = 1;
   localparam int PA = 2;
   localparam int PF = 3;

   logic       clk;
   logic       reset;
   logic       tick;
   logic [3:0] req;
   logic       flash_mode;
   logic [7:0] light;
   logic [2:0] active_dir;
   logic       phase_done;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   // behavioural model: phase, ticks remaining in phase, served approach
   int         m_phase = PG;
   int         m_left  = G;
   int         m_dir   = 0;
   logic [3:0] m_pend  = 4'b0000;
   logic       m_dark  = 1'b0;
   logic       m_done  = 1'b0;

   traffic_ctrl_multi #(
      .N_DIR(4), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(A), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .req(req), .flash_mode(flash_mode),
      .light(light), .active_dir(active_dir), .phase_done(phase_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int choose(input int cur, input logic [3:0] p);
      for (int k = 1; k <= 4; k++) begin
         int j;
         j = (cur + k) % 4;
         if (p[j]) return j;
      end
      return (cur + 1) % 4;
   endfunction

   function automatic logic [7:0] exp_light();
      logic [7:0] e;
      logic [7:0] code;
      e = 8'h00;
      for (int i = 0; i < 4; i++) begin
         if (m_phase == PG)      code = (i == m_dir) ? 8'd0 : 8'd2;
         else if (m_phase == PY) code = (i == m_dir) ? 8'd1 : 8'd2;
         else if (m_phase == PA) code = 8'd2;
         else                    code = m_dark ? 8'd3 : 8'd1;
         e = e | (code << (2 * i));
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // model update from the rules, one clock at a time
   always @(posedge clk or posedge reset) begin : model
      int         n_phase, n_left, n_dir;
      logic       n_dark;
      logic [3:0] upd;
      if (reset) begin
         m_phase <= PG; m_left <= G; m_dir <= 0;
         m_pend <= 4'b0000; m_dark <= 1'b0; m_done <= 1'b0;
      end else begin
         n_phase = m_phase; n_left = m_left; n_dir = m_dir; n_dark = m_dark;
         if (m_phase == PG) begin
            if (flash_mode) begin
               n_phase = PY; n_left = Y;
            end else if (tick) begin
               if (m_left > 1) n_left = m_left - 1;
               else if ((m_pend & ~(4'b0001 << m_dir)) != 4'b0000) begin
                  n_phase = PY; n_left = Y;
               end
            end
         end else if (m_phase == PY) begin
            if (tick) begin
               if (m_left > 1) n_left = m_left - 1;
               else begin n_phase = PA; n_left = A; end
            end
         end else if (m_phase == PA) begin
            if (tick) begin
               if (m_left > 1) n_left = m_left - 1;
               else if (flash_mode) begin n_phase = PF; n_dark = 1'b0; end
               else begin n_phase = PG; n_left = G; n_dir = choose(m_dir, m_pend); end
            end
         end else begin
            if (!flash_mode) begin n_phase = PA; n_left = A; end
            else if (tick) n_dark = ~m_dark;
         end
         upd = m_pend | ((m_phase == PG) ? (req & ~(4'b0001 << m_dir)) : req);
         if (n_phase == PG && m_phase != PG) upd = upd & ~(4'b0001 << n_dir);
         m_done  <= (n_phase != m_phase);
         m_phase <= n_phase; m_left <= n_left; m_dir <= n_dir;
         m_dark  <= n_dark;  m_pend <= upd;
      end
   end

   // cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("light", light, exp_light());
         chk("active_dir", {5'd0, active_dir}, 8'(m_dir));
         chk("phase_done", {7'd0, phase_done}, {7'd0, m_done});
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int hold;
      hold = 0;
      reset = 1'b1; tick = 1'b1; req = 4'b0000; flash_mode = 1'b0;
      step(2);
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_light", light, 8'hA8);
      chk("reset_dir", {5'd0, active_dir}, 8'd0);
      chk("reset_done", {7'd0, phase_done}, 8'd0);

      // dir0 green 4, yellow 2, all-red 1, then dir1
      @(posedge clk); #1;
      reset = 1'b0; req = 4'b0010;
      step(1); req = 4'b0000;
      step(3);
      @(negedge clk) chk("dir0_yellow", light, 8'hA9);
      step(3);
      @(negedge clk);
      chk("dir1_green", light, 8'hA2);
      chk("dir1_active", {5'd0, active_dir}, 8'd1);

      // no demand: green held, then a request for dir3
      step(20);
      @(negedge clk) chk("hold_green", light, 8'hA2);
      step(1); req = 4'b1000;
      step(1); req = 4'b0000;
      step(4);
      @(negedge clk);
      chk("dir3_green", light, 8'h2A);
      chk("dir3_active", {5'd0, active_dir}, 8'd3);

      // flash mode entry and exit
      step(1); flash_mode = 1'b1;
      step(4);
      @(negedge clk) chk("flash_on", light, 8'h55);
      step(1);
      @(negedge clk) chk("flash_dark", light, 8'hFF);
      step(2); flash_mode = 1'b0;
      step(1);
      @(negedge clk) chk("flash_exit_red", light, 8'hAA);
      step(1);
      @(negedge clk);
      chk("flash_exit_green", light, 8'hA8);
      chk("flash_exit_dir", {5'd0, active_dir}, 8'd0);

      // reset while flashing
      step(1); flash_mode = 1'b1;
      step(5);
      reset = 1'b1; flash_mode = 1'b0;
      #1;
      chk("rst_flash_light", light, 8'hA8);
      chk("rst_flash_dir", {5'd0, active_dir}, 8'd0);
      chk("rst_flash_done", {7'd0, phase_done}, 8'd0);
      step(2); reset = 1'b0;

      // reset while yellow
      req = 4'b0010;
      step(1); req = 4'b0000;
      step(3);
      @(negedge clk) chk("pre_rst_yellow", light, 8'hA9);
      reset = 1'b1;
      #1;
      chk("rst_yellow_light", light, 8'hA8);
      chk("rst_yellow_done", {7'd0, phase_done}, 8'd0);
      step(1); reset = 1'b0;

      // randomized traffic, with tick stalls, flash changes and resets
      for (int c = 0; c < 3000; c++) begin
         tick = ($urandom_range(0, 3) != 0);
         if (hold > 0) begin
            tick = 1'b0;
            hold--;
         end else if ($urandom_range(0, 99) == 0) begin
            hold = 10;
         end
         req = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         if ($urandom_range(0, 149) == 0) flash_mode = ~flash_mode;
         reset = ($urandom_range(0, 399) == 0);
         step(1);
      end
      reset = 1'b0;
      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
